// File: rtl/instruction_sequencer.sv
// instruction_sequencer: program store and issue engine for the 8-bit processor.
// Holds DEPTH 18-bit instruction words. On start, each word is presented on id
// for HOLD clocks. Issue stops on the first HALT word (opcode 1000) or at the
// end of memory, which also raises the sticky overrun flag.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a step input. When it is
// defined, each step pulse advances to the next word in place of the HOLD timer.
module instruction_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned HOLD   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [17:0]       load_data,
    input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [17:0]       id,
    output logic              id_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              overrun
);

    localparam int unsigned CNT_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [3:0]  OP_HALT = 4'b1000;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t            state;
    logic [17:0]       mem [DEPTH];
    logic [CNT_W-1:0]  hold_cnt;
    logic [ADDR_W-1:0] next_pc;
    logic [17:0]       first_word;
    logic [17:0]       next_word;
    logic              advance;
    logic              at_end;

    // Combinational program reads from the registered pc, plus the advance decision
    always_comb begin
        next_pc    = pc + 1'b1;
        first_word = mem[0];
        next_word  = mem[next_pc];
        at_end     = (pc == ADDR_W'(DEPTH - 1));
`ifdef SEQ_SINGLE_STEP_EN
        advance    = step;
`else
        advance    = (hold_cnt == CNT_W'(HOLD - 1));
`endif
    end

    // Program store: written only when not issuing. Reset leaves it intact.
    always_ff @(posedge clk) begin
        if (load_en && state != RUN) begin
            mem[load_addr] <= load_data;
        end
    end

    // Issue FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            id       <= '0;
            pc       <= '0;
            hold_cnt <= '0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            id_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    // A simultaneous load takes priority, and start is dropped.
                    if (start && !load_en) begin
                        pc       <= '0;
                        id       <= first_word;
                        hold_cnt <= '0;
                        overrun  <= 1'b0;
                        id_valid <= 1'b1;
                        if (first_word[17:14] == OP_HALT) begin
                            state  <= HALTED;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            halted <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (advance) begin
                        if (at_end) begin
                            state   <= HALTED;
                            id      <= '0;
                            overrun <= 1'b1;
                            busy    <= 1'b0;
                            halted  <= 1'b1;
                        end else begin
                            pc       <= next_pc;
                            id       <= next_word;
                            hold_cnt <= '0;
                            if (next_word[17:14] == OP_HALT) begin
                                state  <= HALTED;
                                busy   <= 1'b0;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program store and issue engine for the 8-bit processor: holds a small program of 18-bit instruction words, and on `start` steps through them. Each word is presented on `id` for a fixed number of clocks, which is the issuing side of the instruction decoder's `id` input. Issue stops on the first HALT word or at the end of memory. The block replaces hand-driven instruction streams, so the decoder can be exercised from a loaded program.

## Interface
- `DEPTH`, 16: program words; must be a power of two, ≥ 2
- `ADDR_W`, 4: log2(DEPTH)
- `HOLD`, 5: clocks each word is held on `id`; must be ≥ 1
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `load_en`  in  1  write `load_data` to `mem[load_addr]`
- `load_addr`  in  ADDR_W  program write address
- `load_data`  in  18  instruction word to store
- `start`  in  1  begin issue from address 0
- `id`  out  18  instruction word to the decoder
- `id_valid`  out  1  high in RUN and HALTED
- `pc`  out  ADDR_W  address of the word currently on `id`
- `busy`  out  1  high in RUN
- `halted`  out  1  high in HALTED
- `overrun`  out  1  memory end reached without a HALT word; sticky until `start` or `rst`

## Operation
- Word format: `[17:14]` opcode, `[13:11]` rd, `[10:8]` rs, `[7:0]` imm.
- Opcodes: 0000 NOP, 0011 SUB, 0110 DEC, 1000 HALT, 1100 MOVI. The block inspects only HALT; all other opcodes pass through unchanged.
- States:
  - IDLE: the reset state.
  - RUN: issuing.
  - HALTED: stopped.
- Loading:
  - `load_en` is honoured only in IDLE and HALTED; it is ignored in RUN.
  - The write occurs at the clock edge.
  - Memory is not cleared by `rst`.
- IDLE/HALTED + `start` (with `load_en`=0): move to RUN.
  - `pc`←0, `id`←`mem[0]`, `hold_cnt`←0, `overrun`←0.
  - If `start` and `load_en` are both high in the same cycle, `start` is ignored and the write proceeds.
- RUN: `hold_cnt` increments each clock. At the edge where `hold_cnt`==HOLD-1:
  - If `pc`==DEPTH-1: move to HALTED, `id`←0 (NOP), `overrun`←1, `pc` holds.
  - Otherwise: `pc`←`pc`+1, `id`←`mem[pc+1]`, `hold_cnt`←0.
- HALT detection applies to every word loaded into `id`, including `mem[0]` at start.
  - If the word's opcode is 1000, the state becomes HALTED at that same edge.
  - `id` then holds the HALT word indefinitely, and `pc` points to it.
- `start` in RUN is ignored.
- `start` in HALTED restarts the program from address 0.
- `rst` at any time, including mid-RUN, takes effect at the next edge and returns all outputs to their reset values.

## Timing
- Reset values: `id`=0, `id_valid`=0, `pc`=0, `busy`=0, `halted`=0, `overrun`=0, state IDLE, `hold_cnt`=0.
- Let E0 be the edge that samples `start`. Word k appears on `id` from edge E0+k·HOLD.
- Latency from `start` to the first word is 1 clock; every output is registered.
- The HALT word at index h appears at E0+h·HOLD. `halted`=1 and `busy`=0 at that same edge.
- Overrun: asserted at edge E0+DEPTH·HOLD.
- Memory read is combinational from the registered `pc`/next-`pc`. A load to address a in HALTED is visible to the next `start`.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - In RUN, the advance condition becomes a `step` pulse instead of `hold_cnt`==HOLD-1, and `hold_cnt` is unused.
  - All HALT and overrun rules are unchanged.
- Undefined: no `step` port; advancement is purely HOLD-timed.

## Test plan
- Reset: load nothing, pulse `rst` → `id`=0, `pc`=0, `busy`/`halted`/`overrun`/`id_valid`=0.
- Normal run, HOLD=5:
  - Stimulus: load mem[0..5] = 110010100011111000, 110011010111001100, 001110111011001100, 011010111011001100, 011010111011001100, 100010111011001100; then `start`.
  - Response: each word is on `id` for 5 clocks. At E0+25, `id`=100010111011001100, `pc`=5, `halted`=1, `busy`=0, and these hold for ≥20 further clocks.
- Overrun, DEPTH=16:
  - Stimulus: fill memory with 011010111011001100 (no HALT), then `start`.
  - Response: at E0+80, `overrun`=1, `halted`=1, `id`=0, `pc`=15.
- Ignored inputs in RUN: `load_en` to address 3 and a `start` pulse at E0+7 → memory unchanged, sequence timing unchanged.
- Restart: after HALTED, load mem[0]=100000000000000000, then `start` → `halted` stays 1, `pc`=0, `id`=100000000000000000 at E0+1 relative to the new start.
- Reset mid-RUN: `rst` at E0+12 → the next edge gives reset values; a following `start` reissues mem[0].
